enc_snapshot_seq: RTL and testbench
===================================

# enc_snapshot_seq

Sequencer that walks the four-channel encoder register file and captures a coherent snapshot of every channel's count, period and frequency words into a double-buffered store. It sits between the encoder register-file read port and the host block-read path. All twelve words in a snapshot are taken within 13 consecutive sysclk cycles, and the host reads a bank that never changes mid-read.

## Interface
Parameters:
- NUM_CH, 4: encoder channels scanned, numbered 1..NUM_CH; legal range 1..4.
- PERIOD_CYCLES, 49152: auto-trigger interval in sysclk cycles; used only with SNAP_AUTO_EN.

Ports:
- sysclk  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- snap_req  in  1  single-cycle snapshot request from the host side.
- enc_raddr  out  16  read address to the encoder register file: {`ADDR_MAIN, 4'h0, ch[3:0], offset[3:0]}.
- enc_rdata  in  32  combinational read data returned for enc_raddr.
- buf_raddr  in  4  host index {ch_idx[1:0], field[1:0]}.
  - ch_idx = ch−1.
  - field: 0 count, 1 period, 2 frequency, 3 snapshot sequence number.
- buf_rdata  out  32  combinational read of the front bank at buf_raddr.
- snap_busy  out  1  high while a scan is in progress.
- snap_done  out  1  one-cycle pulse when a new bank becomes the front bank.
- snap_seq  out  8  count of completed snapshots.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE → RUN when a trigger is seen. A trigger is snap_req, a pending request, or an auto tick. The word counter w is cleared on entry.
- RUN scans words w = 0..3·NUM_CH−1:
  - ch = w/3 + 1.
  - Offset order within a channel: `OFF_ENC_DATA, `OFF_PER_DATA, `OFF_FREQ_DATA.
- RUN is pipelined:
  - The address for word w is driven in cycle w.
  - enc_rdata is captured into the back bank on the following edge, while the address for word w+1 is driven.
  - After the last address is driven, one extra capture cycle follows, then the state moves to DONE.
- DONE (one cycle): back and front banks swap, snap_done=1, snap_seq increments, next state IDLE.
- enc_raddr returns to 0 whenever the state is not RUN.
- Captured data: the full 32-bit enc_rdata is stored unmodified. The count word keeps its overflow bit at bit 24.
- Host reads:
  - field 3 returns {24'h0, snap_seq}.
  - ch_idx ≥ NUM_CH returns 0.
- Pending request: snap_req during RUN or DONE sets a one-deep pending flag. Further requests while the flag is set are merged into it. A pending request starts a new scan on the cycle after DONE.
- Simultaneous snap_req and auto tick in IDLE start exactly one scan, with no pending flag left set.
- snap_seq wraps from 255 to 0.
- Reset, including mid-scan:
  - state IDLE, w=0, pending=0.
  - Both banks cleared to 0, bank select 0.
  - snap_seq=0, snap_busy=0, snap_done=0, enc_raddr=0.
  - Any partial scan is discarded; the front bank is never partially updated.

## Timing
- snap_req high at edge 0 (IDLE):
  - Edge 1: state RUN, snap_busy=1, enc_raddr set to word 0.
  - Edges 1..12: word addresses 0..11 (NUM_CH=4).
  - Edges 2..13: captures of words 0..11.
  - Edge 13: state DONE.
  - Edge 14: bank swap, snap_done=1 for the cycle after edge 14, snap_busy=0.
- Latency from request to snap_done: 3·NUM_CH+2 cycles (14 for NUM_CH=4).
- buf_rdata reflects the new bank in the same cycle that snap_done is high.
- Back-to-back scans: a pending request re-enters RUN at edge 15.
- The encoder register file must present enc_rdata combinationally within the cycle its address is driven.

## Configuration
- SNAP_AUTO_EN defined:
  - A free-running counter counts 0..PERIOD_CYCLES−1 and produces a one-cycle tick on wrap.
  - A tick in IDLE starts a scan; a tick during RUN or DONE sets the pending flag.
  - The counter is cleared by reset.
- SNAP_AUTO_EN undefined: no counter exists; only snap_req triggers scans.

## Test plan
- Basic scan: after reset, model returns enc_rdata = {16'h0, enc_raddr}. Pulse snap_req → snap_done 14 cycles later; buf_raddr 4'h5 reads ch 2 period; snap_seq = 1.
- Coherency: change model data during the scan while reading the front bank → front bank stays 0 until snap_done, then all 12 words update in the same cycle.
- Pending requests: snap_req during RUN at cycles 3 and 7 → exactly one extra scan starting at edge 15; snap_seq = 2.
- Reset mid-scan: assert reset at RUN cycle 6 → all outputs 0, buf_rdata 0 at every index, no snap_done pulse.
- Wrap: 256 scans → snap_seq returns to 0; field-3 read at the last snap_done shows 8'h00.
- Auto-trigger: SNAP_AUTO_EN with PERIOD_CYCLES=100 and no snap_req → snap_done pulses every 100 cycles. A tick coincident with snap_req yields a single scan.

Source files
------------

// File: rtl/enc_snapshot_seq.sv
// Snapshot sequencer: scans NUM_CH encoder channels (count/period/frequency) into a
// double-buffered store. Optional periodic auto-trigger is enabled by defining SNAP_AUTO_EN.

`ifndef ADDR_MAIN
`define ADDR_MAIN 4'h8
`endif
`ifndef OFF_ENC_DATA
`define OFF_ENC_DATA 4'h0
`endif
`ifndef OFF_PER_DATA
`define OFF_PER_DATA 4'h4
`endif
`ifndef OFF_FREQ_DATA
`define OFF_FREQ_DATA 4'h8
`endif

module enc_snapshot_seq #(
    parameter int NUM_CH        = 4,
    parameter int PERIOD_CYCLES = 49152
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        snap_req,
    output logic [15:0] enc_raddr,
    input  logic [31:0] enc_rdata,
    input  logic [3:0]  buf_raddr,
    output logic [31:0] buf_rdata,
    output logic        snap_busy,
    output logic        snap_done,
    output logic [7:0]  snap_seq
);

    localparam int NW = 3 * NUM_CH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  w_q, w_d;
    logic [1:0]  fld_q, fld_d;
    logic [3:0]  ch_q, ch_d;
    logic        pend_q, pend_d;
    logic        bank_q, bank_d;
    logic        done_q, done_d;
    logic [7:0]  seq_q, seq_d;
    logic        tick;
    logic        trigger;
    logic        cap_en;
    logic [3:0]  off;
    logic [31:0] words [0:2*NW-1];

`ifdef SNAP_AUTO_EN
    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    logic [CW-1:0] per_cnt_q;

    assign tick = (per_cnt_q == CW'(PERIOD_CYCLES - 1));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            per_cnt_q <= '0;
        end else if (tick) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= per_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_period = PERIOD_CYCLES;
    assign tick = 1'b0;
`endif

    assign trigger = snap_req | pend_q | tick;
    assign cap_en  = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        fld_d   = fld_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        seq_d   = seq_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_RUN;
                    w_d     = 4'd0;
                    fld_d   = 2'd0;
                    ch_d    = 4'd1;
                    pend_d  = 1'b0;
                end
            end
            ST_RUN: begin
                pend_d = pend_q | snap_req | tick;
                // The last word is captured on the same edge that leaves RUN.
                if (w_q == 4'(NW - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    w_d = w_q + 4'd1;
                    if (fld_q == 2'd2) begin
                        fld_d = 2'd0;
                        ch_d  = ch_q + 4'd1;
                    end else begin
                        fld_d = fld_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                pend_d  = pend_q | snap_req | tick;
                state_d = ST_IDLE;
                bank_d  = ~bank_q;
                done_d  = 1'b1;
                seq_d   = seq_q + 8'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            w_q     <= 4'd0;
            fld_q   <= 2'd0;
            ch_q    <= 4'd1;
            pend_q  <= 1'b0;
            bank_q  <= 1'b0;
            done_q  <= 1'b0;
            seq_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            fld_q   <= fld_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
            seq_q   <= seq_d;
        end
    end

    // Entries 0..NW-1 form bank 0, NW..2*NW-1 bank 1; only the back bank is written.
    for (genvar gi = 0; gi < 2 * NW; gi++) begin : g_word
        logic [31:0] word_q;
        always_ff @(posedge sysclk) begin
            if (reset) begin
                word_q <= '0;
            end else if (cap_en && (bank_q != 1'(gi >= NW)) && (w_q == 4'(gi % NW))) begin
                word_q <= enc_rdata;
            end
        end
        assign words[gi] = word_q;
    end

    always_comb begin
        case (fld_q)
            2'd0:    off = `OFF_ENC_DATA;
            2'd1:    off = `OFF_PER_DATA;
            default: off = `OFF_FREQ_DATA;
        endcase
    end

    assign enc_raddr = cap_en ? {`ADDR_MAIN, 4'h0, ch_q, off} : 16'h0;

    always_comb begin
        logic [1:0] rd_ch;
        logic [1:0] rd_fld;
        logic [4:0] rd_idx;
        rd_ch     = buf_raddr[3:2];
        rd_fld    = buf_raddr[1:0];
        rd_idx    = (bank_q ? 5'(NW) : 5'd0) + 5'(rd_ch) * 5'd3 + 5'(rd_fld);
        buf_rdata = 32'h0;
        if (int'(rd_ch) < NUM_CH) begin
            if (rd_fld == 2'd3) begin
                buf_rdata = {24'h0, seq_q};
            end else begin
                buf_rdata = words[rd_idx];
            end
        end
    end

    assign snap_busy = (state_q != ST_IDLE);
    assign snap_done = done_q;
    assign snap_seq  = seq_q;

endmodule

// File: tb/tb_enc_snapshot_seq.sv
// Self-checking bench for enc_snapshot_seq: directed scans, table readback, and randomized
// requests checked against a scan-schedule reference model.

module tb_enc_snapshot_seq;

    localparam int NUM_CH = 4;
    localparam int NW     = 3 * NUM_CH;
    localparam int P      = 100;
    localparam logic [3:0] A_MAIN = 4'h8;
    localparam logic [3:0] OFF_E  = 4'h0;
    localparam logic [3:0] OFF_P  = 4'h4;
    localparam logic [3:0] OFF_F  = 4'h8;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        snap_req = 1'b0;
    logic [15:0] enc_raddr;
    logic [31:0] enc_rdata;
    logic [3:0]  buf_raddr = 4'h0;
    logic [31:0] buf_rdata;
    logic        snap_busy;
    logic        snap_done;
    logic [7:0]  snap_seq;
    logic [15:0] salt = 16'h0;

    // Encoder register file model: data is the address tagged with a changeable salt.
    assign enc_rdata = {salt, enc_raddr};

    always #5 sysclk = ~sysclk;

    enc_snapshot_seq #(.NUM_CH(NUM_CH), .PERIOD_CYCLES(P)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .snap_req (snap_req),
        .enc_raddr(enc_raddr),
        .enc_rdata(enc_rdata),
        .buf_raddr(buf_raddr),
        .buf_rdata(buf_rdata),
        .snap_busy(snap_busy),
        .snap_done(snap_done),
        .snap_seq (snap_seq)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [16];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a scan started at sampling edge s occupies edges s..s+13.
    int          e_no;
    bit          m_active;
    int          m_s;
    bit          m_pend;
    logic [7:0]  m_seq;
    logic [31:0] m_front [0:NW-1];
    logic [15:0] hist [0:31];
    bit          m_done;
    bit          m_busy;
    logic [15:0] m_raddr;
    int          done_count = 0;
    int          last_done_e = -1;

    function automatic logic [15:0] addr_of(input int w);
        logic [3:0] ch;
        logic [3:0] off;
        ch = 4'(w / 3 + 1);
        case (w % 3)
            0:       off = OFF_E;
            1:       off = OFF_P;
            default: off = OFF_F;
        endcase
        return {A_MAIN, 4'h0, ch, off};
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] idx);
        int ch;
        int f;
        ch = int'(idx[3:2]);
        f  = int'(idx[1:0]);
        if (ch >= NUM_CH) return 32'h0;
        if (f == 3) return {24'h0, m_seq};
        return m_front[ch * 3 + f];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, e_no);
        end
    endtask

    task automatic model_reset();
        e_no     = 0;
        m_active = 0;
        m_s      = 0;
        m_pend   = 0;
        m_seq    = 8'd0;
        m_done   = 0;
        m_busy   = 0;
        m_raddr  = 16'h0;
        for (int i = 0; i < NW; i++) m_front[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        snap_req = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_busy", 32'(snap_busy), 32'h0);
        chk("rst_done", 32'(snap_done), 32'h0);
        chk("rst_seq", 32'(snap_seq), 32'h0);
        chk("rst_raddr", 32'(enc_raddr), 32'h0);
        for (int i = 0; i < 16; i++) begin
            buf_raddr = 4'(i);
            #1;
            chk("rst_buf", buf_rdata, 32'h0);
        end
        model_reset();
        reset = 1'b0;
    endtask

    // One clock: req is sampled on this edge; new salt/read index apply to the following cycle.
    task automatic tick(input bit req, input logic [15:0] new_salt, input logic [3:0] ridx);
        bit auto_tk;
        snap_req = req;
        @(posedge sysclk);
        auto_tk = 0;
`ifdef SNAP_AUTO_EN
        auto_tk = ((e_no % P) == P - 1);
`endif
        m_done = 0;
        if (!m_active) begin
            if (req || m_pend || auto_tk) begin
                m_active = 1;
                m_s      = e_no;
                m_pend   = 0;
            end
        end else begin
            if (req || auto_tk) m_pend = 1;
            if (e_no == m_s + 13) begin
                for (int w = 0; w < NW; w++) m_front[w] = {hist[(m_s + w) % 32], addr_of(w)};
                m_seq    = m_seq + 8'd1;
                m_done   = 1;
                m_active = 0;
            end
        end
        m_busy  = m_active && (e_no - m_s <= 12);
        m_raddr = (m_active && (e_no - m_s <= 11)) ? addr_of(e_no - m_s) : 16'h0;
        #1;
        snap_req        = 1'b0;
        salt            = new_salt;
        hist[e_no % 32] = new_salt;
        buf_raddr       = ridx;
        #1;
        chk("done", 32'(snap_done), 32'(m_done));
        chk("busy", 32'(snap_busy), 32'(m_busy));
        chk("raddr", 32'(enc_raddr), 32'(m_raddr));
        chk("seq", 32'(snap_seq), 32'(m_seq));
        chk("buf", buf_rdata, exp_read(ridx));
        if (snap_done) begin
            done_count++;
            last_done_e = e_no;
            $display("snapshot done at edge %0d, seq=%0d, buf[%h]=%h", e_no, snap_seq, ridx, buf_rdata);
        end
        e_no++;
    endtask

    initial begin
        int e_req;
        int d0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].idx = 4'(i);
            if ((i & 3) == 3) tbl[i].exp = 32'h1;
            else              tbl[i].exp = {16'h0, addr_of((i >> 2) * 3 + (i & 3))};
        end

        // Basic scan with enc_rdata = {16'h0, enc_raddr}
        do_reset();
        e_req = e_no;
        tick(1, 16'h0, 4'h5);
        d0 = done_count;
        for (int k = 0; k < 16; k++) tick(0, 16'h0, 4'h5);
        chk("basic_count", 32'(done_count - d0), 32'h1);
        chk("basic_latency", 32'(last_done_e - e_req + 1), 32'(3 * NUM_CH + 2));
        chk("basic_seq", 32'(snap_seq), 32'h1);
        chk("basic_ch2_per", buf_rdata, 32'h0000_8024);
        for (int i = 0; i < 16; i++) begin
            buf_raddr = tbl[i].idx;
            #1;
            chk("table_read", buf_rdata, tbl[i].exp);
        end

        // Coherency: data changes mid-scan; front stays 0 until the swap
        do_reset();
        for (int k = 0; k < 14; k++) tick(k == 0, (k < 5) ? 16'h1111 : 16'h2222, 4'h0);
        chk("coh_done", 32'(snap_done), 32'h1);
        for (int w = 0; w < NW; w++) begin
            buf_raddr = 4'(((w / 3) << 2) | (w % 3));
            #1;
            chk("coh_word", buf_rdata, {(w < 5) ? 16'h1111 : 16'h2222, addr_of(w)});
        end

        // Pending: requests during RUN merge into one extra scan
        do_reset();
        d0 = done_count;
        for (int k = 0; k < 32; k++) tick(k == 0 || k == 3 || k == 7, 16'h00A5, 4'h3);
        chk("pend_count", 32'(done_count - d0), 32'h2);
        chk("pend_second_done", 32'(last_done_e), 32'd27);
        chk("pend_seq", 32'(snap_seq), 32'h2);

        // Reset mid-scan discards the partial scan
        do_reset();
        for (int k = 0; k < 7; k++) tick(k == 0, 16'h7777, 4'h0);
        do_reset();
        d0 = done_count;
        for (int k = 0; k < 20; k++) tick(0, 16'h0, 4'(k % 16));
        chk("rst_no_done", 32'(done_count - d0), 32'h0);

        // Sequence wrap after 256 scans
        do_reset();
        for (int i = 0; i < 256; i++) begin
            tick(1, 16'($urandom), 4'h3);
            for (int k = 0; k < 13; k++) tick(0, 16'($urandom), 4'h3);
        end
`ifndef SNAP_AUTO_EN
        chk("wrap_done", 32'(snap_done), 32'h1);
        chk("wrap_seq", 32'(snap_seq), 32'h0);
        chk("wrap_field3", buf_rdata, 32'h0);
`endif

        // Randomized requests, data and read indices
        do_reset();
        for (int k = 0; k < 800; k++) begin
            tick($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom_range(0, 15)));
        end

`ifdef SNAP_AUTO_EN
        // Auto trigger every P cycles, and a tick coincident with snap_req
        do_reset();
        d0 = done_count;
        for (int k = 0; k < 3 * P + 20; k++) tick(0, 16'h0, 4'h3);
        chk("auto_count", 32'(done_count - d0), 32'h3);
        while ((e_no % P) != P - 1) tick(0, 16'h0, 4'h3);
        d0 = done_count;
        tick(1, 16'h0, 4'h3);
        for (int k = 0; k < 40; k++) tick(0, 16'h0, 4'h3);
        chk("auto_coincident", 32'(done_count - d0), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
